// File: rtl/router_sync.sv
// router_sync
//
// Purpose: synchronises the packet router's FSM, its three output FIFOs and
// their destinations. The module does four jobs:
//   - It latches the destination address from the header byte.
//   - It decodes that address into a one-hot FIFO write enable.
//   - It returns the addressed FIFO's full flag to the FSM.
//   - It drives a per-channel data-valid signal.
// Optionally, it also watches each channel for a destination that stops
// reading. When that happens it issues a one-cycle soft reset.
//
// Optional feature macro: ROUTER_SYNC_TIMEOUT_EN
//   defined   -> per-channel idle counters and soft_reset_0/1/2 pulses
//   undefined -> no counters; soft_reset_0/1/2 are tied to 0
//
// Ports:
//   clock               rising-edge system clock
//   resetn              asynchronous active-low reset
//   detect_add          load data_in into the address register this edge
//   data_in[1:0]        destination address (00/01/10 valid, 11 = none)
//   write_enb_reg       FSM write request for the current packet
//   read_enb_0/1/2      destination read strobe per channel
//   empty_0/1/2         FIFO empty flag per channel
//   full_0/1/2          FIFO full flag per channel
//   write_enb[2:0]      one-hot FIFO write enable (bit i = channel i)
//   fifo_full           full flag of the addressed channel
//   vld_out_0/1/2       data valid to destination i (= ~empty_i)
//   soft_reset_0/1/2    one-cycle timeout reset for channel i
//
// Parameter:
//   TIMEOUT             consecutive idle cycles before a soft reset (2..31)

module router_sync #(
  parameter int unsigned TIMEOUT = 30
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       detect_add,
  input  logic [1:0] data_in,
  input  logic       write_enb_reg,
  input  logic       read_enb_0,
  input  logic       read_enb_1,
  input  logic       read_enb_2,
  input  logic       empty_0,
  input  logic       empty_1,
  input  logic       empty_2,
  input  logic       full_0,
  input  logic       full_1,
  input  logic       full_2,
  output logic [2:0] write_enb,
  output logic       fifo_full,
  output logic       vld_out_0,
  output logic       vld_out_1,
  output logic       vld_out_2,
  output logic       soft_reset_0,
  output logic       soft_reset_1,
  output logic       soft_reset_2
);

  logic [1:0] addr_q;
  logic [2:0] vld;
  logic [2:0] sr;

  // The address resets to 11 ("no destination"). Because of that, nothing
  // is written until the first header has been decoded.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      addr_q <= 2'b11;
    end else if (detect_add) begin
      addr_q <= data_in;
    end
  end

  // Decoding uses the registered address only. A header strobe that arrives
  // in the same cycle as a write therefore takes effect one cycle later.
  always_comb begin
    write_enb = 3'b000;
    fifo_full = 1'b0;
    case (addr_q)
      2'b00: begin
        write_enb = {2'b00, write_enb_reg};
        fifo_full = full_0;
      end
      2'b01: begin
        write_enb = {1'b0, write_enb_reg, 1'b0};
        fifo_full = full_1;
      end
      2'b10: begin
        write_enb = {write_enb_reg, 2'b00};
        fifo_full = full_2;
      end
      default: begin
        write_enb = 3'b000;
        fifo_full = 1'b0;
      end
    endcase
  end

  assign vld       = ~{empty_2, empty_1, empty_0};
  assign vld_out_0 = vld[0];
  assign vld_out_1 = vld[1];
  assign vld_out_2 = vld[2];

`ifdef ROUTER_SYNC_TIMEOUT_EN
  logic [2:0] rd;
  assign rd = {read_enb_2, read_enb_1, read_enb_0};

  for (genvar i = 0; i < 3; i++) begin : g_timeout
    logic [4:0] idle_cnt;
    logic       sr_q;
    logic       idle;

    assign idle = vld[i] & ~rd[i];

    // The counter holds the number of idle edges already seen. A channel
    // that is still idle when the count reaches TIMEOUT-1 completes TIMEOUT
    // idle cycles on this edge, so it pulses and starts counting again.
    // A read, or an empty FIFO, clears the count. This means a read on the
    // final edge suppresses the pulse.
    always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
        idle_cnt <= 5'd0;
        sr_q     <= 1'b0;
      end else if (!idle) begin
        idle_cnt <= 5'd0;
        sr_q     <= 1'b0;
      end else if (idle_cnt == 5'(TIMEOUT - 1)) begin
        idle_cnt <= 5'd0;
        sr_q     <= 1'b1;
      end else begin
        idle_cnt <= idle_cnt + 5'd1;
        sr_q     <= 1'b0;
      end
    end

    assign sr[i] = sr_q;
  end
`else
  // Without the timeout feature, the read strobes have no function here.
  logic unused_read;
  assign unused_read = &{1'b0, read_enb_0, read_enb_1, read_enb_2};
  assign sr          = 3'b000;
`endif

  assign soft_reset_0 = sr[0];
  assign soft_reset_1 = sr[1];
  assign soft_reset_2 = sr[2];

endmodule

// File: tb/tb_router_sync.sv
// Testbench for router_sync.
// The bench starts with a table of combinational decode vectors. Each vector
// is applied, checked, and then clocked, so the address register carries
// over into the next row. Hand-written sequences follow. They cover
// asynchronous reset, the idle timeout with its repeat, read suppression,
// simultaneous pulses across channels, and reset in the middle of a count.
// Soft-reset expectations depend on whether ROUTER_SYNC_TIMEOUT_EN is
// defined.

module tb_router_sync;

  logic       clock;
  logic       resetn;
  logic       detect_add;
  logic [1:0] data_in;
  logic       write_enb_reg;
  logic [2:0] rd;
  logic [2:0] empty;
  logic [2:0] full;
  logic [2:0] write_enb;
  logic       fifo_full;
  logic       vld_out_0, vld_out_1, vld_out_2;
  logic       soft_reset_0, soft_reset_1, soft_reset_2;

  int total;
  int bad;

`ifdef ROUTER_SYNC_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  router_sync #(.TIMEOUT(30)) dut (
    .clock        (clock),
    .resetn       (resetn),
    .detect_add   (detect_add),
    .data_in      (data_in),
    .write_enb_reg(write_enb_reg),
    .read_enb_0   (rd[0]),
    .read_enb_1   (rd[1]),
    .read_enb_2   (rd[2]),
    .empty_0      (empty[0]),
    .empty_1      (empty[1]),
    .empty_2      (empty[2]),
    .full_0       (full[0]),
    .full_1       (full[1]),
    .full_2       (full[2]),
    .write_enb    (write_enb),
    .fifo_full    (fifo_full),
    .vld_out_0    (vld_out_0),
    .vld_out_1    (vld_out_1),
    .vld_out_2    (vld_out_2),
    .soft_reset_0 (soft_reset_0),
    .soft_reset_1 (soft_reset_1),
    .soft_reset_2 (soft_reset_2)
  );

  // ---------------- clock ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [2:0] sr_vec();
    return {soft_reset_2, soft_reset_1, soft_reset_0};
  endfunction

  function automatic logic [2:0] vld_vec();
    return {vld_out_2, vld_out_1, vld_out_0};
  endfunction

  // Assert reset for one edge and release it 1 time unit after that edge.
  task automatic do_reset();
    resetn = 1'b0;
    step();
    resetn = 1'b1;
  endtask

  // Run n edges. After each edge, check the soft-reset vector against an
  // expected pulse mask on edges p1 and p2 (counted from 1). Use 0 for none.
  task automatic run_idle(input string name, input int n, input int p1,
                          input int p2, input logic [2:0] mask);
    logic [2:0] exp;
    for (int k = 1; k <= n; k++) begin
      step();
      exp = (TO_EN && (k == p1 || k == p2)) ? mask : 3'b000;
      check($sformatf("%s_k%0d", name, k), {5'd0, sr_vec()}, {5'd0, exp});
    end
  endtask

  // ---------------- decode vector table ----------------
  typedef struct {
    logic       da;
    logic [1:0] din;
    logic       wer;
    logic [2:0] full;
    logic [2:0] empty;
    logic [2:0] exp_we;
    logic       exp_ff;
    logic [2:0] exp_vld;
  } vec_t;

  vec_t tbl[12];

  initial begin
    total = 0;
    bad   = 0;
    resetn        = 1'b0;
    detect_add    = 1'b0;
    data_in       = 2'b00;
    write_enb_reg = 1'b0;
    rd            = 3'b111;
    empty         = 3'b111;
    full          = 3'b000;

    //         da    din    wer   full    empty   we      ff    vld
    tbl[0]  = '{1'b0, 2'b00, 1'b1, 3'b111, 3'b111, 3'b000, 1'b0, 3'b000}; // reset addr 11
    tbl[1]  = '{1'b1, 2'b01, 1'b0, 3'b010, 3'b101, 3'b000, 1'b0, 3'b010}; // load 01
    tbl[2]  = '{1'b0, 2'b00, 1'b1, 3'b010, 3'b000, 3'b010, 1'b1, 3'b111};
    tbl[3]  = '{1'b1, 2'b11, 1'b1, 3'b010, 3'b110, 3'b010, 1'b1, 3'b001}; // old addr this cycle
    tbl[4]  = '{1'b0, 2'b00, 1'b1, 3'b111, 3'b111, 3'b000, 1'b0, 3'b000}; // addr 11
    tbl[5]  = '{1'b1, 2'b00, 1'b1, 3'b001, 3'b111, 3'b000, 1'b0, 3'b000}; // load 00
    tbl[6]  = '{1'b1, 2'b10, 1'b1, 3'b100, 3'b111, 3'b001, 1'b0, 3'b000}; // load 10, still 00
    tbl[7]  = '{1'b0, 2'b00, 1'b1, 3'b100, 3'b111, 3'b100, 1'b1, 3'b000};
    tbl[8]  = '{1'b0, 2'b00, 1'b0, 3'b100, 3'b111, 3'b000, 1'b1, 3'b000};
    tbl[9]  = '{1'b1, 2'b00, 1'b0, 3'b001, 3'b111, 3'b000, 1'b0, 3'b000}; // load 00
    tbl[10] = '{1'b0, 2'b00, 1'b1, 3'b001, 3'b111, 3'b001, 1'b1, 3'b000};
    tbl[11] = '{1'b0, 2'b00, 1'b0, 3'b000, 3'b011, 3'b000, 1'b0, 3'b100};

    // Reset: address register at 11, so nothing is decoded.
    #2;
    check("rst_we", {5'd0, write_enb}, 8'h00);
    check("rst_ff", {7'd0, fifo_full}, 8'h00);
    check("rst_sr", {5'd0, sr_vec()}, 8'h00);
    step();
    step();
    resetn = 1'b1;

    for (int i = 0; i < 12; i++) begin
      detect_add    = tbl[i].da;
      data_in       = tbl[i].din;
      write_enb_reg = tbl[i].wer;
      full          = tbl[i].full;
      empty         = tbl[i].empty;
      #1;
      check($sformatf("tbl%0d_we", i), {5'd0, write_enb}, {5'd0, tbl[i].exp_we});
      check($sformatf("tbl%0d_ff", i), {7'd0, fifo_full}, {7'd0, tbl[i].exp_ff});
      check($sformatf("tbl%0d_vld", i), {5'd0, vld_vec()}, {5'd0, tbl[i].exp_vld});
      check($sformatf("tbl%0d_sr", i), {5'd0, sr_vec()}, 8'h00);
      step();
    end

    // Asynchronous reset in mid-cycle clears the address with no clock edge.
    detect_add    = 1'b0;
    write_enb_reg = 1'b1;
    full          = 3'b111;
    empty         = 3'b111;
    #1;
    check("pre_areset_we", {5'd0, write_enb}, 8'h01);  // address 00 from row 9
    resetn = 1'b0;
    #1;
    check("areset_we", {5'd0, write_enb}, 8'h00);
    check("areset_ff", {7'd0, fifo_full}, 8'h00);
    check("areset_vld", {5'd0, vld_vec()}, 8'h00);
    check("areset_sr", {5'd0, sr_vec()}, 8'h00);
    step();
    resetn = 1'b1;
    step();
    check("post_reset_we", {5'd0, write_enb}, 8'h00);
    check("post_reset_ff", {7'd0, fifo_full}, 8'h00);
    write_enb_reg = 1'b0;
    full          = 3'b000;

    // Channel 0 idle: pulses on edges 30 and 60; other channels stay 0.
    do_reset();
    empty = 3'b110;
    rd    = 3'b000;
    run_idle("idle0", 65, 30, 60, 3'b001);

    // Channel 2: a read on the 30th edge suppresses the pulse, and the count
    // restarts from the read.
    rd    = 3'b111;
    empty = 3'b111;
    do_reset();
    empty = 3'b011;
    rd    = 3'b000;
    run_idle("pre_read2", 29, 0, 0, 3'b100);
    rd = 3'b100;
    step();
    check("read2_suppress", {5'd0, sr_vec()}, 8'h00);
    rd = 3'b000;
    run_idle("post_read2", 31, 30, 0, 3'b100);

    // All three channels idle together, so they pulse together.
    rd    = 3'b111;
    empty = 3'b111;
    do_reset();
    empty = 3'b000;
    rd    = 3'b000;
    run_idle("idle_all", 31, 30, 0, 3'b111);

    // Reset in the middle of a count discards the partial count.
    rd    = 3'b111;
    empty = 3'b111;
    do_reset();
    empty = 3'b110;
    rd    = 3'b000;
    run_idle("pre_mid", 10, 0, 0, 3'b001);
    resetn = 1'b0;
    #2;
    check("mid_reset_sr", {5'd0, sr_vec()}, 8'h00);
    #2;
    resetn = 1'b1;
    run_idle("post_mid", 31, 30, 0, 3'b001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
